axis_uart_tx: RTL

UART transmitter consuming an AXI4-Stream byte stream and serialising it onto `txd`. Sits directly downstream of the TX-path synchronous stream FIFO: its `s_axis_*` slave port connects to the FIFO's master port, and `txd` drives the chip pin. Frame format is start bit, `DATA_WIDTH` data bits LSB first, optional parity bit, one stop bit. Bit period is set at run time by `prescale`.

---
 rtl/axis_uart_tx_if.sv | 17 +
 rtl/axis_uart_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axis_uart_tx_if.sv
// rtl/axis_uart_tx_if.sv - byte stream handshake bundle for the UART transmitter
//
// Purpose : groups the stream data/valid/ready signals feeding axis_uart_tx.
// Signals : tdata  - word to transmit (DATA_WIDTH bits)
//           tvalid - upstream has a word
//           tready - downstream accepts the word this cycle
// Modports: master (stream source, e.g. the TX FIFO), slave (the transmitter)
interface axis_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_tx.sv
// rtl/axis_uart_tx.sv - stream-fed UART transmitter (start, data LSB first, optional parity, stop)
//
// Purpose : serialises each accepted stream word onto txd using a run-time
//           bit period. Frame settings are captured on the accepting edge.
// Ports   : clk        - clock, rising edge
//           rst_n      - asynchronous active-low reset
//           s_axis     - stream slave port (tdata/tvalid/tready)
//           txd        - serial output, idle high, driven from a flop
//           busy       - frame in progress
//           prescale   - clocks per bit (0 behaves as 1)
//           parity_en  - 1 appends a parity bit
//           parity_odd - 1 odd parity, 0 even parity
module axis_uart_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   axis_uart_tx_if.slave             s_axis,
   output logic                      txd,
   output logic                      busy,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      parity_en,
   input  logic                      parity_odd
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [PRESCALE_WIDTH-1:0] timer_q, timer_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]     shift_q, shift_d;
   logic                      par_en_q, par_en_d;
   logic                      parity_q, parity_d;
   logic                      txd_q, txd_d;
   logic                      busy_q, busy_d;
   logic                      tready_q, tready_d;
   logic                      bit_end;

   // Timer tops out at prescale_q-1, so an all-ones prescale never wraps it.
   assign bit_end = (timer_q == prescale_q - PRESCALE_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         prescale_q <= PRESCALE_WIDTH'(1);
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         parity_q   <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         tready_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         prescale_q <= prescale_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_en_q   <= par_en_d;
         parity_q   <= parity_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         tready_q   <= tready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = bit_end ? '0 : timer_q + PRESCALE_WIDTH'(1);
      prescale_d = prescale_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_en_d   = par_en_q;
      parity_d   = parity_q;
      txd_d      = txd_q;
      busy_d     = busy_q;
      tready_d   = tready_q;

      case (state_q)
         IDLE: begin
            timer_d  = '0;
            txd_d    = 1'b1;
            busy_d   = 1'b0;
            tready_d = 1'b1;
            if (s_axis.tvalid && tready_q) begin
               // Capture everything the frame depends on; later input changes
               // only affect the next frame.
               state_d    = START;
               shift_d    = s_axis.tdata;
               prescale_d = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
               par_en_d   = parity_en;
               parity_d   = (^s_axis.tdata) ^ parity_odd;
               bit_cnt_d  = '0;
               txd_d      = 1'b0;
               busy_d     = 1'b1;
               tready_d   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = par_en_q ? PARITY : STOP;
                  txd_d   = par_en_q ? parity_q : 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
                  shift_d   = shift_q >> 1;
                  txd_d     = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               txd_d   = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d  = IDLE;
               txd_d    = 1'b1;
               busy_d   = 1'b0;
               tready_d = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            txd_d    = 1'b1;
            busy_d   = 1'b0;
            tready_d = 1'b0;
         end
      endcase
   end

   assign txd           = txd_q;
   assign busy          = busy_q;
   assign s_axis.tready = tready_q;

endmodule
